// File: rtl/jpeg_raster_to_block.sv
// Raster-to-block reorder for JPEG encoding.
// Collects 8 raster rows of RGB pixels into a strip buffer, then replays
// the strip as 8x8 blocks, one strip at a time. Fill and drain are
// strictly sequential, so a single strip buffer is enough.
module jpeg_raster_to_block #(
  parameter int unsigned MAX_BLK_W = 8,
  parameter int unsigned MAX_BLK_H = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(MAX_BLK_W+1)-1:0]   cfg_blk_w,
  input  logic [$clog2(MAX_BLK_H+1)-1:0]   cfg_blk_h,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [23:0]                      in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_data,
  output logic                             out_last_block,
  output logic                             out_first_pix,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err
);

  localparam int unsigned BW   = $clog2(MAX_BLK_W + 1);
  localparam int unsigned BH   = $clog2(MAX_BLK_H + 1);
  localparam int unsigned NCOL = MAX_BLK_W * 8;
  localparam int unsigned CW   = $clog2(NCOL);

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  state_e state_q, state_d;

  // Latched image geometry
  logic [BW-1:0] w_q;
  logic [BH-1:0] h_q;

  // Fill-side counters
  logic [2:0]    wr_row_q;
  logic [CW-1:0] wr_col_q;

  // Drain-side counters; rd_done_q marks that the strip's last pixel is already loaded
  logic [BW-1:0] rd_blk_q;
  logic [2:0]    rd_y_q;
  logic [2:0]    rd_x_q;
  logic          rd_done_q;
  logic [BH-1:0] strip_q;

  // Output register flags; out_end_q tags the last pixel of the strip
  logic out_valid_q;
  logic out_first_q;
  logic out_last_blk_q;
  logic out_end_q;
  logic done_q;
  logic cfg_err_q;

  logic [23:0] pix_buf [8][NCOL];

  logic          cfg_ok;
  logic          start_ok;
  logic          start_bad;
  logic [BW+2:0] w_pix;
  logic [CW-1:0] col_max;
  logic [BW-1:0] blk_max;
  logic          in_fire;
  logic          wr_last;
  logic          out_fire;
  logic          strip_end;
  logic          last_strip;
  logic          load;
  logic          rd_last;
  logic [CW-1:0] rd_col;

  assign cfg_ok = (cfg_blk_w != '0) && (cfg_blk_w <= BW'(MAX_BLK_W)) &&
                  (cfg_blk_h != '0) && (cfg_blk_h <= BH'(MAX_BLK_H));
  assign start_ok  = (state_q == StIdle) && start && cfg_ok;
  assign start_bad = (state_q == StIdle) && start && !cfg_ok;

  assign w_pix   = {w_q, 3'b000} - (BW+3)'(1);
  assign col_max = CW'(w_pix);
  assign blk_max = w_q - BW'(1);

  assign in_fire    = in_valid && (state_q == StFill);
  assign wr_last    = (wr_row_q == 3'd7) && (wr_col_q == col_max);
  assign out_fire   = out_valid_q && out_ready;
  assign strip_end  = out_fire && out_end_q;
  assign last_strip = (strip_q == h_q - BH'(1));
  assign load       = (state_q == StDrain) && !rd_done_q && (!out_valid_q || out_ready);
  assign rd_last    = (rd_y_q == 3'd7) && (rd_x_q == 3'd7) && (rd_blk_q == blk_max);
  // {blk, x} is blk*8 + x
  assign rd_col     = CW'({rd_blk_q, rd_x_q});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start_ok) state_d = StFill;
      end
      StFill: begin
        in_ready = 1'b1;
        if (in_fire && wr_last) state_d = StDrain;
      end
      StDrain: begin
        if (strip_end) state_d = last_strip ? StIdle : StFill;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Config latch and one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q       <= '0;
      h_q       <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      if (start_ok) begin
        w_q <= cfg_blk_w;
        h_q <= cfg_blk_h;
      end
      cfg_err_q <= start_bad;
      done_q    <= (state_q == StDrain) && strip_end && last_strip;
    end
  end

  // Fill counters: column runs across the configured width, then row advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_row_q <= '0;
      wr_col_q <= '0;
    end else if (state_q == StIdle) begin
      wr_row_q <= '0;
      wr_col_q <= '0;
    end else if (in_fire) begin
      if (wr_col_q == col_max) begin
        wr_col_q <= '0;
        wr_row_q <= wr_row_q + 3'd1;
      end else begin
        wr_col_q <= wr_col_q + CW'(1);
      end
    end
  end

  // Drain counters: x fastest, then y, then block; strip index advances per strip
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_blk_q  <= '0;
      rd_y_q    <= '0;
      rd_x_q    <= '0;
      rd_done_q <= 1'b0;
      strip_q   <= '0;
    end else if (state_q == StIdle) begin
      rd_blk_q  <= '0;
      rd_y_q    <= '0;
      rd_x_q    <= '0;
      rd_done_q <= 1'b0;
      strip_q   <= '0;
    end else begin
      if (load) begin
        rd_x_q <= rd_x_q + 3'd1;
        if (rd_x_q == 3'd7) begin
          rd_y_q <= rd_y_q + 3'd1;
          if (rd_y_q == 3'd7) begin
            rd_blk_q <= rd_last ? '0 : rd_blk_q + BW'(1);
          end
        end
        if (rd_last) rd_done_q <= 1'b1;
      end
      if (strip_end) begin
        rd_done_q <= 1'b0;
        if (!last_strip) strip_q <= strip_q + BH'(1);
      end
    end
  end

  // Output register control; flags only change on a load or a drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_first_q    <= 1'b0;
      out_last_blk_q <= 1'b0;
      out_end_q      <= 1'b0;
    end else if (load) begin
      out_valid_q    <= 1'b1;
      out_first_q    <= (rd_y_q == 3'd0) && (rd_x_q == 3'd0);
      out_last_blk_q <= last_strip && (rd_blk_q == blk_max);
      out_end_q      <= rd_last;
    end else if (out_ready) begin
      out_valid_q    <= 1'b0;
      out_first_q    <= 1'b0;
      out_last_blk_q <= 1'b0;
      out_end_q      <= 1'b0;
    end
  end

  // Strip buffer write and output data; neither is reset
  always_ff @(posedge clk) begin
    if (in_fire) pix_buf[wr_row_q][wr_col_q] <= in_data;
    if (load)    out_data <= {8'h00, pix_buf[rd_y_q][rd_col]};
  end

  assign out_valid      = out_valid_q;
  assign out_first_pix  = out_first_q;
  assign out_last_block = out_last_blk_q;
  assign done           = done_q;
  assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_jpeg_raster_to_block.sv
// Self-checking bench for jpeg_raster_to_block: table of image/config
// vectors plus hand-written reset and latency sequences.
module tb_jpeg_raster_to_block;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_blk_w = '0;
  logic [6:0]  cfg_blk_h = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last_block;
  logic        out_first_pix;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int errors = 0;
  int checks = 0;

  jpeg_raster_to_block dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_blk_w      (cfg_blk_w),
    .cfg_blk_h      (cfg_blk_h),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last_block (out_last_block),
    .out_first_pix  (out_first_pix),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int h;
    bit rnd;
    bit drain_start;
    bit exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Raster input pixel: strip*4096 + row*(W*8) + col
  function automatic logic [23:0] in_pix(input int idx, input int w);
    int s, r, row, col;
    s   = idx / (64 * w);
    r   = idx % (64 * w);
    row = r / (8 * w);
    col = r % (8 * w);
    return 24'(s * 4096 + row * 8 * w + col);
  endfunction

  // Expected k-th output pixel in block order
  function automatic logic [23:0] out_pix(input int k, input int w);
    int s, r, b, y, x;
    s = k / (64 * w);
    r = k % (64 * w);
    b = r / 64;
    y = (r % 64) / 8;
    x = r % 8;
    return 24'(s * 4096 + y * 8 * w + b * 8 + x);
  endfunction

  task automatic run_image(input int w, input int h, input bit rnd, input bit drain_start);
    int total, in_idx, out_idx, done_cnt, err_cnt, since, post, budget, s, b;
    bit stall, pulsed, sf, sl;
    logic [31:0] sd;
    total = 64 * w * h;
    in_idx = 0; out_idx = 0; done_cnt = 0; err_cnt = 0; since = 0; post = 0;
    budget = total * 4 + 100;
    stall = 0; pulsed = 0; sf = 0; sl = 0; sd = '0;
    @(negedge clk);
    cfg_blk_w = 4'(w);
    cfg_blk_h = 7'(h);
    start = 1'b1;
    for (int cyc = 0; cyc < budget && post < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (drain_start && !pulsed && out_idx == 5) begin
        start = 1'b1;
        cfg_blk_w = 4'd1;
        cfg_blk_h = 7'd1;
        pulsed = 1;
      end
      if (done) done_cnt++;
      if (cfg_err) err_cnt++;
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, sd);
        chk("stall_flags", {30'd0, out_first_pix, out_last_block}, {30'd0, sf, sl});
      end
      if (since == 1) begin
        chk("fill_drain_gap", {29'd0, out_valid, in_ready, busy}, 32'b001);
        since = 2;
      end else if (since == 2) begin
        chk("drain_first_valid", 32'(out_valid), 32'd1);
        since = 0;
      end
      chk("no_overlap", 32'(out_valid & in_ready), 32'd0);
      if (out_idx == total) begin
        post++;
        chk("no_extra_valid", 32'(out_valid), 32'd0);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = (in_idx < total);
      in_data = in_valid ? in_pix(in_idx, w) : 24'd0;
      if (in_valid && in_ready) begin
        in_idx++;
        if (in_idx % (64 * w) == 0) since = 1;
      end
      if (out_valid && out_ready && out_idx < total) begin
        s = out_idx / (64 * w);
        b = (out_idx % (64 * w)) / 64;
        chk("out_data", out_data, {8'h00, out_pix(out_idx, w)});
        chk("out_first_pix", 32'(out_first_pix), 32'((out_idx % 64) == 0));
        chk("out_last_block", 32'(out_last_block), 32'(s == h - 1 && b == w - 1));
        out_idx++;
      end
      stall = out_valid && !out_ready;
      sd = out_data;
      sf = out_first_pix;
      sl = out_last_block;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("out_count", 32'(out_idx), 32'(total));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("cfg_err_quiet", 32'(err_cnt), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic bad_start(input int w, input int h);
    @(negedge clk);
    cfg_blk_w = 4'(w);
    cfg_blk_h = 7'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", {30'd0, cfg_err, busy}, 32'b10);
    @(negedge clk);
    chk("cfg_err_clear", {30'd0, cfg_err, busy}, 32'b00);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{w: 1, h: 1, rnd: 0, drain_start: 0, exp_err: 0};
    vecs[1] = '{w: 2, h: 1, rnd: 0, drain_start: 0, exp_err: 0};
    vecs[2] = '{w: 2, h: 2, rnd: 1, drain_start: 0, exp_err: 0};
    vecs[3] = '{w: 0, h: 1, rnd: 0, drain_start: 0, exp_err: 1};
    vecs[4] = '{w: 9, h: 1, rnd: 0, drain_start: 0, exp_err: 1};
    vecs[5] = '{w: 1, h: 0, rnd: 0, drain_start: 0, exp_err: 1};
    vecs[6] = '{w: 2, h: 1, rnd: 0, drain_start: 1, exp_err: 0};
    vecs[7] = '{w: 8, h: 2, rnd: 0, drain_start: 0, exp_err: 0};
    vecs[8] = '{w: 1, h: 3, rnd: 1, drain_start: 0, exp_err: 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {25'd0, out_valid, in_ready, busy, done, cfg_err, out_first_pix, out_last_block},
        32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].exp_err) bad_start(vecs[i].w, vecs[i].h);
      else run_image(vecs[i].w, vecs[i].h, vecs[i].rnd, vecs[i].drain_start);
    end

    // Reset in the middle of a W=2 fill, after 100 pixels
    @(negedge clk);
    cfg_blk_w = 4'd2;
    cfg_blk_h = 7'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int cyc = 0; cyc < 300 && cnt < 100; cyc++) begin
      in_valid = 1'b1;
      in_data = in_pix(cnt, 2);
      if (in_ready) cnt++;
      @(negedge clk);
    end
    chk("fill_count_before_rst", 32'(cnt), 32'd100);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_fill", {29'd0, out_valid, in_ready, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("no_accept_without_start", {30'd0, in_ready, busy}, 32'd0);
    in_valid = 1'b0;
    run_image(1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_raster_to_block.md
JPEG_RASTER_TO_BLOCK -- requirements
Module: jpeg_raster_to_block

Interface
REQ-001 Parameter MAX_BLK_W, default 8: maximum image width in 8-pixel blocks; the line buffer holds 8 rows of MAX_BLK_W*8 pixels.
REQ-002 Parameter MAX_BLK_H, default 64: maximum image height in 8-row strips.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  single-cycle pulse that samples the config and begins an image.
REQ-006 cfg_blk_w  input  $clog2(MAX_BLK_W+1)  image width in blocks.
REQ-007 cfg_blk_h  input  $clog2(MAX_BLK_H+1)  image height in strips.
REQ-008 in_valid / in_ready / in_data  input / output / 24  raster-order RGB pixel stream, left to right then top to bottom.
REQ-009 out_valid / out_ready / out_data  output / input / 32  block-order pixel stream; out_data = {8'h00, RGB}.
REQ-010 out_last_block  output  1  high for all 64 pixels of the image's final block.
REQ-011 out_first_pix  output  1  high on pixel 0 of every block.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when the final pixel of the image is accepted downstream.
REQ-014 cfg_err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-015 The state machine SHALL have the states IDLE, FILL and DRAIN.
REQ-016 In IDLE, a start with 1<=cfg_blk_w<=MAX_BLK_W and 1<=cfg_blk_h<=MAX_BLK_H SHALL latch both fields and enter FILL on the next cycle.
- Any other start SHALL pulse cfg_err on the next cycle and remain in IDLE.
REQ-017 A start outside IDLE SHALL be ignored: no cfg_err, and the latched config is unchanged.
REQ-018 in_ready SHALL equal (state==FILL); a pixel is accepted on a cycle with in_valid && in_ready.
REQ-019 Each accepted pixel SHALL be written to buf[row][col]; col increments 0..W*8-1 and then wraps to 0 while row increments 0..7.
REQ-020 When pixel (row 7, col W*8-1) is accepted, the state SHALL change to DRAIN on the next cycle.
REQ-021 In DRAIN the read order SHALL be: block b=0..W-1, then y=0..7, then x=0..7, reading buf[y][b*8+x].
REQ-022 The output register SHALL load the next pixel when !out_valid || out_ready.
- out_valid SHALL first assert on the cycle after DRAIN entry (1-cycle latency).
- out_data, out_first_pix and out_last_block SHALL hold stable while out_valid && !out_ready.
REQ-023 On acceptance of the strip's 64*W-th output pixel, the block SHALL proceed as follows:
- If the strip index < H-1, increment the strip index and return to FILL.
- Otherwise, pulse done on the next cycle and return to IDLE.
- The final pixel SHALL NOT be followed by an extra out_valid cycle.
REQ-024 out_last_block SHALL be high iff strip==H-1 and b==W-1.
REQ-025 FILL and DRAIN SHALL NOT overlap: in_ready is 0 during DRAIN, and out_valid is 0 during FILL.
REQ-026 All counters SHALL be sized for the MAX parameters; no counter SHALL exceed its configured limit or wrap into an unused buffer column.
REQ-027 W=1 and H=1 SHALL be legal: a single block of 64 pixels with out_last_block high throughout.

Reset
REQ-028 While rst is high, the block SHALL force:
- state to IDLE and all counters to 0;
- out_valid, out_first_pix, out_last_block, busy, done and cfg_err to 0;
- in_ready to 0.
REQ-029 Buffer contents and out_data SHALL NOT be reset.
REQ-030 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the image; the first pixel after reset is accepted only after a new start.

Verification
REQ-031 Start with W=1, H=1, and input pixels with value = index 0..63, out_ready=1 -> output 0..63 in order; out_last_block high throughout; done pulses once.
REQ-032 Start with W=2, H=1, and pixel value = row*16+col -> first block outputs 0x00..0x07, 0x10..0x17, ...; the second block starts at 0x08; out_first_pix is high at outputs 0 and 64.
REQ-033 Start with W=2, H=2, and out_ready toggling randomly -> 256 outputs with no drops or duplicates; out_last_block only on outputs 192..255; data stable under stall.
REQ-034 Start with cfg_blk_w=0, then with cfg_blk_w=MAX_BLK_W+1 -> cfg_err pulses each time; busy stays 0.
REQ-035 Assert rst after 100 pixels of a W=2 FILL -> out_valid=0 and in_ready=0 immediately; a new start with W=1, H=1 completes normally.
REQ-036 Pulse start during DRAIN -> ignored; the image completes with the original config.
